// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//  Shared definitions for the RV32Core data cache:
//   - default address-field widths (words per line, number of sets)
//   - cache controller state encoding
// ---------------------------------------------------------------------------
package cache_pkg;

    // log2(words per line) and log2(number of sets) used as module defaults
    localparam int CACHE_LINE_ADDR_LEN = 3;
    localparam int CACHE_SET_ADDR_LEN  = 4;
    localparam int CACHE_TAG_ADDR_LEN  = 32 - 2 - CACHE_LINE_ADDR_LEN - CACHE_SET_ADDR_LEN;

    // Controller states
    //  IDLE       : serve hits, detect misses
    //  SWAP_OUT   : write the dirty victim line back to memory
    //  SWAP_IN    : fetch the missing line from memory
    //  SWAP_IN_OK : install the fetched line, then return to IDLE
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } cache_state_t;

endpackage

// File: rtl/dcache_wb_dm.sv
// ---------------------------------------------------------------------------
// dcache_wb_dm
//  Direct-mapped, write-back, write-allocate data cache between the MEM stage
//  and main memory. Word hits complete with no added latency; on a miss the
//  pipeline is stalled via `miss` while the victim line is optionally written
//  back and the requested line is refilled over a line-wide handshake.
//
// Ports
//  clk, rst      : clock, asynchronous active-high reset
//  rd_req/wr_req : word load / store request (both set = store)
//  addr          : byte address (bits[1:0] ignored)
//  wr_data       : store data
//  rd_data       : load data, valid when rd_req && !miss, else 0
//  miss          : stall, request not yet satisfied
//  mem_rd_req    : line refill request, held until mem_gnt
//  mem_wr_req    : line write-back request, held until mem_gnt
//  mem_addr      : line-aligned address of the current memory op (0 when idle)
//  mem_wr_line   : victim line for write-back
//  mem_rd_line   : refill line, valid in the mem_gnt cycle of a read
//  mem_gnt       : one-cycle completion pulse for the outstanding memory op
// ---------------------------------------------------------------------------
module dcache_wb_dm
    import cache_pkg::*;
#(
    parameter int LINE_ADDR_LEN = CACHE_LINE_ADDR_LEN,
    parameter int SET_ADDR_LEN  = CACHE_SET_ADDR_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_req,
    input  logic                            wr_req,
    input  logic [31:0]                     addr,
    input  logic [31:0]                     wr_data,
    output logic [31:0]                     rd_data,
    output logic                            miss,
    output logic                            mem_rd_req,
    output logic                            mem_wr_req,
    output logic [31:0]                     mem_addr,
    output logic [(32<<LINE_ADDR_LEN)-1:0]  mem_wr_line,
    input  logic [(32<<LINE_ADDR_LEN)-1:0]  mem_rd_line,
    input  logic                            mem_gnt
);

    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int WORDS        = 1 << LINE_ADDR_LEN;
    localparam int SETS         = 1 << SET_ADDR_LEN;
    localparam int OFFS         = LINE_ADDR_LEN + 2;   // byte offset bits within a line

    typedef logic [WORDS-1:0][31:0] line_t;

    // ------------------------------------------------------------------
    // Address split
    // ------------------------------------------------------------------
    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  tag;
    logic                     addr_unused;

    assign word_idx    = addr[OFFS-1:2];
    assign set_idx     = addr[SET_ADDR_LEN+OFFS-1:OFFS];
    assign tag         = addr[31:SET_ADDR_LEN+OFFS];
    assign addr_unused = ^addr[1:0];   // byte lane bits are irrelevant for word access

    // ------------------------------------------------------------------
    // Cache state
    // ------------------------------------------------------------------
    logic [SETS-1:0]          valid_reg;
    logic [SETS-1:0]          dirty_reg;
    logic [TAG_ADDR_LEN-1:0]  tag_reg  [SETS];
    line_t                    line_reg [SETS];

    cache_state_t             state_reg;
    logic [TAG_ADDR_LEN-1:0]  miss_tag_reg;
    logic [SET_ADDR_LEN-1:0]  miss_set_reg;
    line_t                    fill_reg;        // refill line held for one cycle before install

    // ------------------------------------------------------------------
    // Hit / miss detection (combinational, zero added latency on hit)
    // ------------------------------------------------------------------
    logic req;
    logic hit;
    logic store_hit;
    logic victim_dirty;

    assign req          = rd_req | wr_req;
    assign hit          = req && valid_reg[set_idx] && (tag_reg[set_idx] == tag)
                          && (state_reg == IDLE);
    assign miss         = req && !hit;
    assign store_hit    = hit && wr_req;
    assign victim_dirty = valid_reg[set_idx] && dirty_reg[set_idx];

    assign rd_data      = hit ? line_reg[set_idx][word_idx] : 32'd0;

    // The victim set does not change during SWAP_OUT, so the line can be
    // presented straight from storage.
    assign mem_wr_line  = line_reg[miss_set_reg];

    // ------------------------------------------------------------------
    // Controller FSM with registered memory-side outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            valid_reg    <= '0;
            dirty_reg    <= '0;
            miss_tag_reg <= '0;
            miss_set_reg <= '0;
            mem_rd_req   <= 1'b0;
            mem_wr_req   <= 1'b0;
            mem_addr     <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (store_hit) begin
                        dirty_reg[set_idx] <= 1'b1;
                    end else if (miss) begin
                        miss_tag_reg <= tag;
                        miss_set_reg <= set_idx;
                        if (victim_dirty) begin
                            // write back the resident line under its own tag first
                            state_reg  <= SWAP_OUT;
                            mem_wr_req <= 1'b1;
                            mem_addr   <= {tag_reg[set_idx], set_idx, {OFFS{1'b0}}};
                        end else begin
                            state_reg  <= SWAP_IN;
                            mem_rd_req <= 1'b1;
                            mem_addr   <= {tag, set_idx, {OFFS{1'b0}}};
                        end
                    end
                end

                SWAP_OUT: begin
                    if (mem_gnt) begin
                        state_reg  <= SWAP_IN;
                        mem_wr_req <= 1'b0;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {miss_tag_reg, miss_set_reg, {OFFS{1'b0}}};
                    end
                end

                SWAP_IN: begin
                    if (mem_gnt) begin
                        state_reg  <= SWAP_IN_OK;
                        mem_rd_req <= 1'b0;
                        mem_addr   <= 32'd0;
                    end
                end

                SWAP_IN_OK: begin
                    // the refill completes even if the core dropped its request
                    valid_reg[miss_set_reg] <= 1'b1;
                    dirty_reg[miss_set_reg] <= 1'b0;
                    state_reg               <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line and tag storage (not cleared by reset; valid bits guard it)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_reg == SWAP_IN && mem_gnt) begin
            fill_reg <= mem_rd_line;
        end
        if (state_reg == SWAP_IN_OK) begin
            line_reg[miss_set_reg] <= fill_reg;
            tag_reg[miss_set_reg]  <= miss_tag_reg;
        end else if (store_hit) begin
            line_reg[set_idx][word_idx] <= wr_data;
        end
    end

endmodule
